// File: rtl/mem_dma.sv
// mem_dma: single-channel word-copy DMA engine.
// Reads len words from src and writes them to dst, one word per cycle, with
// each write trailing its read by one cycle. Optional build macro DMA_FILL_EN
// adds a fill mode that writes a constant pattern without issuing reads.
module mem_dma #(
  parameter int unsigned LENW = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  input  logic [31:2]     src,
  input  logic [31:2]     dst,
  input  logic [LENW-1:0] len,
`ifdef DMA_FILL_EN
  input  logic            fill,
  input  logic [31:0]     fill_data,
`endif
  output logic            busy,
  output logic            done,
  output logic            rready,
  output logic [31:2]     raddr,
  input  logic [31:0]     rdata,
  output logic            wready,
  output logic [31:2]     waddr,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [LENW-1:0] cnt_q, cnt_d;       // operations left, including the current one
  logic [31:2]     wptr_q, wptr_d;     // next write address
  logic            fill_q, fill_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rready_q, rready_d;
  logic [31:2]     raddr_q, raddr_d;
  logic            wready_q, wready_d;
  logic [31:2]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     wdata_c;
  logic            fill_in;
  logic [31:0]     fill_val;

`ifdef DMA_FILL_EN
  assign fill_in  = fill;
  assign fill_val = fill_data;
`else
  assign fill_in  = 1'b0;
  assign fill_val = 32'h0;
`endif

  // Copy writes carry the memory's read data straight through (it arrives the
  // same cycle the write is issued); otherwise the held value is presented.
  assign wdata_c = (wready_q && !fill_q) ? rdata : wdata_q;

  assign busy   = busy_q;
  assign done   = done_q;
  assign rready = rready_q;
  assign raddr  = raddr_q;
  assign wready = wready_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_c;
  assign wstrb  = wstrb_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    fill_d   = fill_q;
    rready_d = 1'b0;
    raddr_d  = raddr_q;
    wready_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_c;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            cnt_d   = len;
            fill_d  = fill_in;
            if (fill_in) begin
              wready_d = 1'b1;
              waddr_d  = dst;
              wptr_d   = dst + 30'(1);
              wdata_d  = fill_val;
            end else begin
              rready_d = 1'b1;
              raddr_d  = src;
              wptr_d   = dst;
            end
          end
        end
      end
      S_READ: begin
        cnt_d = cnt_q - LENW'(1);
        if (cnt_q == LENW'(1)) begin
          state_d = fill_q ? S_DONE : S_DRAIN;
        end else if (fill_q) begin
          wready_d = 1'b1;
          waddr_d  = wptr_q;
          wptr_d   = wptr_q + 30'(1);
        end else begin
          rready_d = 1'b1;
          raddr_d  = raddr_q + 30'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A copy read issued this cycle becomes a write next cycle.
    if (rready_q) begin
      wready_d = 1'b1;
      waddr_d  = wptr_q;
      wptr_d   = wptr_q + 30'(1);
    end

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    wstrb_d = {4{wready_d}};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wptr_q   <= '0;
      fill_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rready_q <= 1'b0;
      raddr_q  <= '0;
      wready_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rready_q <= rready_d;
      raddr_q  <= raddr_d;
      wready_q <= wready_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: self-checking bench for mem_dma with a word memory model
// (same-address write-to-read forwarding) and a sequential-copy reference.
module tb_mem_dma;

  localparam int unsigned LENW = 16;

  logic            clk = 1'b0;
  logic            resetb;
  logic            start;
  logic [31:2]     src, dst;
  logic [LENW-1:0] len;
  logic            busy, done, rready, wready;
  logic [31:2]     raddr, waddr;
  logic [31:0]     rdata, wdata;
  logic [3:0]      wstrb;
`ifdef DMA_FILL_EN
  logic            fill;
  logic [31:0]     fill_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem  [bit [29:0]];
  logic [31:0] refm [bit [29:0]];

  // Observations of one transfer
  logic [29:0] obs_raddr[$];
  logic [29:0] obs_waddr[$];
  logic [31:0] obs_wdata[$];
  int          obs_rcyc[$];
  int          obs_wcyc[$];
  int          obs_done_cyc, obs_done_cnt, obs_busy_cnt, obs_strb_bad;

  // Expected sequences from the reference
  logic [31:0] exp_wdata[$];

  always #5 clk = ~clk;

  mem_dma #(.LENW(LENW)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
`ifdef DMA_FILL_EN
    .fill     (fill),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done),
    .rready   (rready),
    .raddr    (raddr),
    .rdata    (rdata),
    .wready   (wready),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb)
  );

  function automatic logic [31:0] rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [29:0] a);
    if (refm.exists(a)) return refm[a];
    return 32'h0;
  endfunction

  // Memory: write commits first, so a same-address read sees the new word.
  initial rdata = 32'h0;
  always @(posedge clk) begin
    if (wready === 1'b1) mem[waddr] = wdata;
    if (rready === 1'b1) rdata <= rd(raddr);
  end

  // Sequential forward copy reference: word k reads the memory as it stands
  // after words 0..k-1 have been written.
  task automatic model_copy(input logic [29:0] s, input logic [29:0] d, input int n);
    logic [31:0] v;
    refm = mem;
    exp_wdata.delete();
    for (int k = 0; k < n; k++) begin
      v = rd_ref(s + 30'(k));
      exp_wdata.push_back(v);
      refm[d + 30'(k)] = v;
    end
  endtask

  // Issue one start and record every access until done (bounded).
  task automatic do_xfer(input logic [29:0] s, input logic [29:0] d, input int n,
                         input bit f, input logic [31:0] fd, input bit poke);
    obs_raddr.delete(); obs_waddr.delete(); obs_wdata.delete();
    obs_rcyc.delete();  obs_wcyc.delete();
    obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_cnt = 0; obs_strb_bad = 0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = LENW'(n);
`ifdef DMA_FILL_EN
    fill = f; fill_data = fd;
`endif
    for (int cyc = 1; cyc <= n + 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1; src = 30'h2aaa; dst = 30'h1555; len = LENW'(5);
      end
      if (poke && cyc == 3) start = 1'b0;
      if (rready === 1'b1) begin obs_raddr.push_back(raddr); obs_rcyc.push_back(cyc); end
      if (wready === 1'b1) begin
        obs_waddr.push_back(waddr); obs_wdata.push_back(wdata); obs_wcyc.push_back(cyc);
      end
      if (busy === 1'b1) obs_busy_cnt++;
      if (done === 1'b1) begin obs_done_cnt++; obs_done_cyc = cyc; end
      if (wstrb !== ((wready === 1'b1) ? 4'hf : 4'h0)) obs_strb_bad++;
      if (obs_done_cnt > 0 && cyc >= obs_done_cyc + 2) break;
    end
    if (f || fd != 32'h0) begin end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, rready, wready, wstrb, raddr, waddr, wdata} !== '0)
      $display("FAIL reset_outputs got b%0b d%0b r%0b w%0b s%h ra%h wa%h wd%h want all 0",
               busy, done, rready, wready, wstrb, raddr, waddr, wdata);
    else n_pass++;
    @(negedge clk); resetb = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, rready, wready} !== 4'b0)
      $display("FAIL reset_release_idle got %b want 0000", {busy, done, rready, wready});
    else n_pass++;
  endtask

  task automatic test_copy();
    for (int k = 0; k < 4; k++) begin
      mem[30'h100 + 30'(k)] = 32'hA0 + 32'(k);
      mem[30'h200 + 30'(k)] = 32'h0;
    end
    do_xfer(30'h100, 30'h200, 4, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (obs_rcyc.size() !== 4 || obs_rcyc[0] !== 1 || obs_rcyc[3] !== 4)
      $display("FAIL copy_rready_cycles got n=%0d want 4 at cycles 1..4", obs_rcyc.size());
    else n_pass++;
    n_checks++;
    if (obs_wcyc.size() !== 4 || obs_wcyc[0] !== 2 || obs_wcyc[3] !== 5)
      $display("FAIL copy_wready_cycles got n=%0d want 4 at cycles 2..5", obs_wcyc.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rd(30'h200 + 30'(k)) !== 32'hA0 + 32'(k))
        $display("FAIL copy_mem[%0d] got %h want %h", k, rd(30'h200 + 30'(k)), 32'hA0 + 32'(k));
      else n_pass++;
    end
    n_checks++;
    if (obs_done_cnt !== 1 || obs_done_cyc !== 6)
      $display("FAIL copy_done got cnt=%0d cyc=%0d want cnt=1 cyc=6", obs_done_cnt, obs_done_cyc);
    else n_pass++;
    n_checks++;
    if (obs_busy_cnt !== 6 || obs_strb_bad !== 0)
      $display("FAIL copy_busy_strb got busy=%0d strb_bad=%0d want 6 and 0", obs_busy_cnt, obs_strb_bad);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    do_xfer(30'h100, 30'h300, 0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (obs_rcyc.size() !== 0 || obs_wcyc.size() !== 0)
      $display("FAIL zero_len_access got reads=%0d writes=%0d want 0 0", obs_rcyc.size(), obs_wcyc.size());
    else n_pass++;
    n_checks++;
    if (obs_done_cnt !== 1 || obs_done_cyc !== 1 || obs_busy_cnt !== 1)
      $display("FAIL zero_len_done got cnt=%0d cyc=%0d busy=%0d want 1 1 1",
               obs_done_cnt, obs_done_cyc, obs_busy_cnt);
    else n_pass++;
  endtask

  task automatic test_overlap();
    mem[30'h10] = 32'd5;
    for (int k = 1; k < 5; k++) mem[30'h10 + 30'(k)] = 32'd0;
    do_xfer(30'h10, 30'h11, 3, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (rd(30'h10 + 30'(k)) !== 32'd5)
        $display("FAIL overlap_mem[%0h] got %0d want 5", 30'h10 + 30'(k), rd(30'h10 + 30'(k)));
      else n_pass++;
    end
    n_checks++;
    if (rd(30'h14) !== 32'd0) $display("FAIL overlap_past_end got %0d want 0", rd(30'h14));
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [29:0] want [4];
    want[0] = 30'h3ffffffe; want[1] = 30'h3fffffff; want[2] = 30'h0; want[3] = 30'h1;
    for (int k = 0; k < 4; k++) mem[want[k]] = $urandom;
    model_copy(30'h3ffffffe, 30'h500, 4);
    do_xfer(30'h3ffffffe, 30'h500, 4, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (obs_raddr.size() !== 4)
      $display("FAIL wrap_read_count got %0d want 4", obs_raddr.size());
    else if (obs_raddr[0] !== want[0] || obs_raddr[1] !== want[1] ||
             obs_raddr[2] !== want[2] || obs_raddr[3] !== want[3])
      $display("FAIL wrap_raddr got %h %h %h %h want 3ffffffe 3fffffff 0 1",
               obs_raddr[0], obs_raddr[1], obs_raddr[2], obs_raddr[3]);
    else n_pass++;
    n_checks++;
    if (rd(30'h503) !== exp_wdata[3])
      $display("FAIL wrap_data got %h want %h", rd(30'h503), exp_wdata[3]);
    else n_pass++;
  endtask

  task automatic test_random_copy();
    logic [29:0] s, d;
    int n, bad;
    for (int it = 0; it < 24; it++) begin
      for (int a = 0; a < 64; a++) mem[30'h1000 + 30'(a)] = $urandom;
      n = int'($urandom_range(16, 1));
      s = 30'h1000 + 30'($urandom_range(24, 0));
      d = 30'h1000 + 30'($urandom_range(24, 0));
      model_copy(s, d, n);
      do_xfer(s, d, n, 1'b0, 32'h0, (it % 2) == 1);
      bad = 0;
      if (obs_raddr.size() != n || obs_waddr.size() != n) bad = 1;
      else for (int k = 0; k < n; k++) begin
        if (obs_raddr[k] !== s + 30'(k) || obs_rcyc[k] !== k + 1) bad = 1;
        if (obs_waddr[k] !== d + 30'(k) || obs_wcyc[k] !== k + 2) bad = 1;
        if (obs_wdata[k] !== exp_wdata[k]) bad = 1;
      end
      n_checks++;
      if (bad != 0)
        $display("FAIL rand_seq it=%0d s=%h d=%h n=%0d got reads=%0d writes=%0d want %0d each in order",
                 it, s, d, n, obs_raddr.size(), obs_waddr.size(), n);
      else n_pass++;
      bad = 0;
      for (int a = 0; a < 48; a++)
        if (rd(30'h1000 + 30'(a)) !== rd_ref(30'h1000 + 30'(a))) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL rand_mem it=%0d got %0d bad words want 0", it, bad);
      else n_pass++;
      n_checks++;
      if (obs_done_cnt !== 1 || obs_done_cyc !== n + 2 || obs_busy_cnt !== n + 2 || obs_strb_bad !== 0)
        $display("FAIL rand_timing it=%0d got done=%0d@%0d busy=%0d strb_bad=%0d want 1@%0d busy=%0d 0",
                 it, obs_done_cnt, obs_done_cyc, obs_busy_cnt, obs_strb_bad, n + 2, n + 2);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    for (int k = 0; k < 8; k++) mem[30'h380 + 30'(k)] = 32'h0;
    @(negedge clk);
    start = 1'b1; src = 30'h300; dst = 30'h380; len = LENW'(8);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    resetb = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, rready, wready, wstrb, raddr, waddr, wdata} !== '0)
      $display("FAIL midreset_outputs got b%0b d%0b r%0b w%0b s%h ra%h wa%h wd%h want all 0",
               busy, done, rready, wready, wstrb, raddr, waddr, wdata);
    else n_pass++;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || rready === 1'b1 || wready === 1'b1) seen++;
    end
    resetb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || rready === 1'b1 || wready === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || rd(30'h380) !== 32'h0)
      $display("FAIL midreset_abandon got %0d active cycles mem=%h want 0 and 0", seen, rd(30'h380));
    else n_pass++;
    for (int k = 0; k < 3; k++) mem[30'h600 + 30'(k)] = 32'h5000 + 32'(k);
    do_xfer(30'h600, 30'h680, 3, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (obs_done_cnt !== 1 || obs_done_cyc !== 5 || rd(30'h682) !== 32'h5002)
      $display("FAIL midreset_restart got done=%0d@%0d mem=%h want 1@5 00005002",
               obs_done_cnt, obs_done_cyc, rd(30'h682));
    else n_pass++;
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    int bad;
    for (int k = 0; k < 4; k++) mem[30'h40 + 30'(k)] = 32'h0;
    do_xfer(30'h123, 30'h40, 3, 1'b1, 32'hDEADBEEF, 1'b0);
    n_checks++;
    if (obs_raddr.size() !== 0) $display("FAIL fill_no_reads got %0d reads want 0", obs_raddr.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 3; k++) if (rd(30'h40 + 30'(k)) !== 32'hDEADBEEF) bad++;
    if (rd(30'h43) !== 32'h0) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL fill_mem got %0d bad words want 0", bad);
    else n_pass++;
    n_checks++;
    if (obs_wcyc.size() !== 3 || obs_wcyc[0] !== 1 || obs_done_cnt !== 1 || obs_done_cyc !== 4)
      $display("FAIL fill_timing got writes=%0d done=%0d@%0d want 3 from cycle 1, 1@4",
               obs_wcyc.size(), obs_done_cnt, obs_done_cyc);
    else n_pass++;
    fill = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_zero_len();
    test_overlap();
    test_wrap();
    test_random_copy();
    test_mid_reset();
`ifdef DMA_FILL_EN
    test_fill();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
